// File: rtl/dispatch_demux_1to2.sv
// dispatch_demux_1to2: buffered 1-to-2 demux with a DEPTH-entry FIFO per branch and synchronous flush
module dispatch_demux_1to2 #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 2,
    localparam int PW        = $clog2(DEPTH),
    localparam int CW        = PW + 1
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  FLUSH,
    input  logic [DATA_WIDTH-1:0] IN_DATA,
    input  logic                  IN_SELECT,
    input  logic                  IN_VALID,
    output logic                  IN_READY,
    output logic [DATA_WIDTH-1:0] OUT1_DATA,
    output logic                  OUT1_VALID,
    input  logic                  OUT1_READY,
    output logic [DATA_WIDTH-1:0] OUT2_DATA,
    output logic                  OUT2_VALID,
    input  logic                  OUT2_READY,
    output logic [CW-1:0]         OUT1_COUNT,
    output logic [CW-1:0]         OUT2_COUNT
);
    logic [DATA_WIDTH-1:0] mem_q [2][DEPTH];
    logic [DATA_WIDTH-1:0] mem_d [2][DEPTH];
    logic [PW-1:0]         wr_q [2];
    logic [PW-1:0]         wr_d [2];
    logic [PW-1:0]         rd_q [2];
    logic [PW-1:0]         rd_d [2];
    logic [CW-1:0]         cnt_q [2];
    logic [CW-1:0]         cnt_d [2];
    logic                  full [2];
    logic                  push [2];
    logic                  pop [2];
    logic                  out_rdy [2];

    // Handshake decode and next state for both branches; a full branch never accepts, even while popping
    always_comb begin
        out_rdy[0] = OUT1_READY;
        out_rdy[1] = OUT2_READY;
        for (int b = 0; b < 2; b++) full[b] = cnt_q[b] == CW'(DEPTH);
        IN_READY = ~FLUSH & ~full[IN_SELECT];
        mem_d = mem_q;
        for (int b = 0; b < 2; b++) begin
            push[b] = IN_VALID & IN_READY & (IN_SELECT == 1'(b));
            pop[b]  = (cnt_q[b] != '0) & out_rdy[b] & ~FLUSH;
            if (push[b]) mem_d[b][wr_q[b]] = IN_DATA;
            wr_d[b]  = FLUSH ? '0 : wr_q[b] + PW'(push[b]);
            rd_d[b]  = FLUSH ? '0 : rd_q[b] + PW'(pop[b]);
            cnt_d[b] = FLUSH ? '0 : cnt_q[b] + CW'(push[b]) - CW'(pop[b]);
        end
    end

    // Branch state registers; reset clears memory too so outputs start from a known state
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            mem_q <= '{default: '0};
            for (int b = 0; b < 2; b++) begin
                wr_q[b]  <= '0;
                rd_q[b]  <= '0;
                cnt_q[b] <= '0;
            end
        end else begin
            mem_q <= mem_d;
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    // Outputs are pure functions of registered state; data reads as zero when a branch is empty
    always_comb begin
        OUT1_VALID = cnt_q[0] != '0;
        OUT2_VALID = cnt_q[1] != '0;
        OUT1_DATA  = OUT1_VALID ? mem_q[0][rd_q[0]] : '0;
        OUT2_DATA  = OUT2_VALID ? mem_q[1][rd_q[1]] : '0;
        OUT1_COUNT = cnt_q[0];
        OUT2_COUNT = cnt_q[1];
    end
endmodule

// File: tb/tb_dispatch_demux_1to2.sv
// tb_dispatch_demux_1to2: directed and random checks of the buffered 1-to-2 demux
module tb_dispatch_demux_1to2;
    localparam int DEPTH = 2;

    logic        clk = 0;
    logic        rst = 1;
    logic        flush = 0;
    logic [31:0] in_data = 0;
    logic        in_sel = 0;
    logic        in_valid = 0;
    logic        in_ready;
    logic [31:0] o1_data, o2_data;
    logic        o1_valid, o2_valid;
    logic        o1_ready = 0, o2_ready = 0;
    logic [1:0]  o1_cnt, o2_cnt;
    int          total = 0;
    int          bad = 0;

    dispatch_demux_1to2 #(.DATA_WIDTH(32), .DEPTH(DEPTH)) dut (
        .CLK(clk), .RESET(rst), .FLUSH(flush),
        .IN_DATA(in_data), .IN_SELECT(in_sel), .IN_VALID(in_valid), .IN_READY(in_ready),
        .OUT1_DATA(o1_data), .OUT1_VALID(o1_valid), .OUT1_READY(o1_ready),
        .OUT2_DATA(o2_data), .OUT2_VALID(o2_valid), .OUT2_READY(o2_ready),
        .OUT1_COUNT(o1_cnt), .OUT2_COUNT(o2_cnt)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        in_sel = 0; in_data = 32'h77; in_valid = 1;
        cyc();
        in_valid = 0;
        total++; if (o1_cnt !== 2'd1) begin bad++; $display("FAIL reset_pre_cnt got=%0d want=1", o1_cnt); end
        #3 rst = 1;
        #1;
        total++; if ({o1_valid, o2_valid} !== 2'b00) begin bad++; $display("FAIL reset_valid got=%b want=00", {o1_valid, o2_valid}); end
        total++; if ({o1_cnt, o2_cnt} !== 4'h0) begin bad++; $display("FAIL reset_cnt got=%h want=0", {o1_cnt, o2_cnt}); end
        total++; if ({o1_data, o2_data} !== 64'h0) begin bad++; $display("FAIL reset_data got=%h want=0", {o1_data, o2_data}); end
        in_sel = 0; #1;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_rdy_sel0 got=%b want=1", in_ready); end
        in_sel = 1; #1;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_rdy_sel1 got=%b want=1", in_ready); end
        cyc();
        rst = 0;
    endtask

    task automatic test_routing();
        o1_ready = 1; o2_ready = 1;
        in_sel = 0; in_data = 32'hAAAA0001; in_valid = 1;
        #1;
        total++; if (o1_valid !== 1'b0) begin bad++; $display("FAIL route_no_bypass got=%b want=0", o1_valid); end
        cyc();
        in_sel = 1; in_data = 32'hBBBB0002;
        total++; if (o1_data !== 32'hAAAA0001 || o1_valid !== 1'b1) begin bad++; $display("FAIL route_out1 got=%h/%b want=aaaa0001/1", o1_data, o1_valid); end
        total++; if (o2_data !== 32'h0 || o2_valid !== 1'b0) begin bad++; $display("FAIL route_out2_idle got=%h/%b want=0/0", o2_data, o2_valid); end
        cyc();
        in_valid = 0;
        total++; if (o2_data !== 32'hBBBB0002 || o2_valid !== 1'b1) begin bad++; $display("FAIL route_out2 got=%h/%b want=bbbb0002/1", o2_data, o2_valid); end
        total++; if (o1_data !== 32'h0 || o1_valid !== 1'b0) begin bad++; $display("FAIL route_out1_drained got=%h/%b want=0/0", o1_data, o1_valid); end
        cyc();
        total++; if ({o1_cnt, o2_cnt} !== 4'h0) begin bad++; $display("FAIL route_empty got=%h want=0", {o1_cnt, o2_cnt}); end
    endtask

    task automatic test_full();
        o1_ready = 0; o2_ready = 0;
        in_sel = 0; in_data = 32'h11; in_valid = 1;
        cyc();
        in_data = 32'h22;
        cyc();
        in_valid = 0; #1;
        total++; if (o1_cnt !== 2'd2) begin bad++; $display("FAIL full_cnt got=%0d want=2", o1_cnt); end
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL full_rdy_sel0 got=%b want=0", in_ready); end
        total++; if (o1_data !== 32'h11) begin bad++; $display("FAIL full_head got=%h want=11", o1_data); end
        in_sel = 1; in_data = 32'h33; in_valid = 1; #1;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL full_rdy_sel1 got=%b want=1", in_ready); end
        cyc();
        in_valid = 0;
        total++; if (o2_cnt !== 2'd1 || o2_data !== 32'h33) begin bad++; $display("FAIL full_other_push got=%0d/%h want=1/33", o2_cnt, o2_data); end
        in_sel = 0; o1_ready = 1; #1;
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL full_no_passthru got=%b want=0", in_ready); end
        cyc();
        total++; if (o1_data !== 32'h22 || o1_cnt !== 2'd1) begin bad++; $display("FAIL drain_1 got=%h/%0d want=22/1", o1_data, o1_cnt); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL drain_rdy got=%b want=1", in_ready); end
        cyc();
        total++; if (o1_valid !== 1'b0 || o1_cnt !== 2'd0) begin bad++; $display("FAIL drain_2 got=%b/%0d want=0/0", o1_valid, o1_cnt); end
        o2_ready = 1;
        cyc();
        o1_ready = 0; o2_ready = 0;
        total++; if (o2_cnt !== 2'd0) begin bad++; $display("FAIL drain_b2 got=%0d want=0", o2_cnt); end
    endtask

    task automatic test_simul();
        in_sel = 0; in_data = 32'h44; in_valid = 1;
        cyc();
        for (int i = 0; i < 9; i++) begin
            o1_ready = 1; in_data = 32'h55 + i; in_valid = 1;
            #1;
            total++; if (o1_data !== (i == 0 ? 32'h44 : 32'h55 + i - 1)) begin bad++; $display("FAIL simul_head[%0d] got=%h want=%h", i, o1_data, (i == 0 ? 32'h44 : 32'h55 + i - 1)); end
            cyc();
            total++; if (o1_cnt !== 2'd1) begin bad++; $display("FAIL simul_cnt[%0d] got=%0d want=1", i, o1_cnt); end
        end
        in_valid = 0;
        total++; if (o1_data !== 32'h5D) begin bad++; $display("FAIL simul_last got=%h want=5d", o1_data); end
        cyc();
        o1_ready = 0;
        total++; if (o1_cnt !== 2'd0) begin bad++; $display("FAIL simul_empty got=%0d want=0", o1_cnt); end
    endtask

    task automatic test_flush();
        o1_ready = 0; o2_ready = 0; in_valid = 1;
        for (int i = 0; i < 4; i++) begin
            in_sel = i[1]; in_data = 32'hF0 + i;
            cyc();
        end
        total++; if ({o1_cnt, o2_cnt} !== 4'b1010) begin bad++; $display("FAIL flush_pre got=%h want=a", {o1_cnt, o2_cnt}); end
        flush = 1; o1_ready = 1; o2_ready = 1; in_sel = 0; #1;
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL flush_rdy got=%b want=0", in_ready); end
        cyc();
        flush = 0; in_valid = 0; o1_ready = 0; o2_ready = 0;
        total++; if ({o1_cnt, o2_cnt} !== 4'h0 || {o1_valid, o2_valid} !== 2'b00) begin bad++; $display("FAIL flush_clear got=%h/%b want=0/00", {o1_cnt, o2_cnt}, {o1_valid, o2_valid}); end
        total++; if ({o1_data, o2_data} !== 64'h0) begin bad++; $display("FAIL flush_data got=%h want=0", {o1_data, o2_data}); end
        in_sel = 1; in_data = 32'h99; in_valid = 1;
        cyc();
        in_valid = 0;
        total++; if (o2_data !== 32'h99 || o2_cnt !== 2'd1 || o1_cnt !== 2'd0) begin bad++; $display("FAIL flush_after got=%h/%0d/%0d want=99/1/0", o2_data, o2_cnt, o1_cnt); end
        flush = 1;
        cyc();
        flush = 0;
    endtask

    task automatic test_random();
        logic [31:0] q1[$];
        logic [31:0] q2[$];
        logic        exp_rdy;
        for (int c = 0; c < 10000; c++) begin
            in_sel = 1'($urandom_range(1));
            in_valid = 1'($urandom_range(1));
            o1_ready = 1'($urandom_range(1));
            o2_ready = 1'($urandom_range(1));
            flush = $urandom_range(99) == 0;
            in_data = $urandom;
            #1;
            exp_rdy = !flush && (in_sel ? q2.size() < DEPTH : q1.size() < DEPTH);
            total++; if (in_ready !== exp_rdy) begin bad++; $display("FAIL rand_rdy c=%0d got=%b want=%b", c, in_ready, exp_rdy); end
            total++; if (o1_cnt !== 2'(q1.size()) || o1_data !== (q1.size() != 0 ? q1[0] : 32'h0)) begin bad++; $display("FAIL rand_b1 c=%0d got=%0d/%h want=%0d/%h", c, o1_cnt, o1_data, q1.size(), q1.size() != 0 ? q1[0] : 32'h0); end
            total++; if (o2_cnt !== 2'(q2.size()) || o2_data !== (q2.size() != 0 ? q2[0] : 32'h0)) begin bad++; $display("FAIL rand_b2 c=%0d got=%0d/%h want=%0d/%h", c, o2_cnt, o2_data, q2.size(), q2.size() != 0 ? q2[0] : 32'h0); end
            total++; if (o1_valid !== (q1.size() != 0) || o2_valid !== (q2.size() != 0)) begin bad++; $display("FAIL rand_valid c=%0d got=%b%b", c, o1_valid, o2_valid); end
            if (flush) begin
                q1.delete();
                q2.delete();
            end else begin
                if (o1_ready && q1.size() != 0) void'(q1.pop_front());
                if (o2_ready && q2.size() != 0) void'(q2.pop_front());
                if (in_valid && exp_rdy) begin
                    if (in_sel) q2.push_back(in_data);
                    else q1.push_back(in_data);
                end
            end
            cyc();
        end
        flush = 0; in_valid = 0; o1_ready = 0; o2_ready = 0;
    endtask

    initial begin
        cyc();
        cyc();
        rst = 0;
        cyc();
        test_reset();
        test_routing();
        test_full();
        test_simul();
        test_flush();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/dispatch_demux_1to2.md
# dispatch_demux_1to2

Buffered 1-to-2 demultiplexer for the RV32IM execute stage: steers one 32-bit operand/result stream to one of two consumers, e.g. the single-cycle ALU path and the multi-cycle MUL/DIV unit. Each branch has its own DEPTH-entry FIFO with a valid/ready handshake, so a stalled consumer back-pressures only the traffic selected for it. A synchronous FLUSH clears both branches on a branch mispredict.

## Interface
- DATA_WIDTH, 32, width of the data word
- DEPTH, 2, entries per branch FIFO; power of two, at least 2
- CLK  input  1  clock; all state updates on the rising edge
- RESET  input  1  asynchronous, active-high; clears all state
- FLUSH  input  1  synchronous clear of both FIFOs
- IN_DATA  input  DATA_WIDTH  word offered by the producer
- IN_SELECT  input  1  destination: 0 routes to branch 1, 1 routes to branch 2
- IN_VALID  input  1  producer has a word on IN_DATA
- IN_READY  output  1  the selected branch can accept the word this cycle
- OUT1_DATA  output  DATA_WIDTH  head of branch 1; 0 when branch 1 is empty
- OUT1_VALID  output  1  branch 1 is non-empty
- OUT1_READY  input  1  consumer 1 takes the head
- OUT2_DATA, OUT2_VALID, OUT2_READY  same as branch 1, for branch 2
- OUT1_COUNT, OUT2_COUNT  output  $clog2(DEPTH)+1  occupancy of each branch

## Operation
- Each branch is a circular FIFO of DEPTH registers with a write pointer, a read pointer and a count. Pointers wrap modulo DEPTH. Entries leave in the order they were accepted.
- IN_READY = ~FLUSH & ~full[IN_SELECT]. It depends combinationally on IN_SELECT and on registered state only.
- Push: when IN_VALID & IN_READY, IN_DATA is written to the FIFO chosen by IN_SELECT. The other branch is untouched.
- Pop on branch n: when OUTn_VALID & OUTn_READY & ~FLUSH, the head is removed.
- Same-cycle push and pop on one branch: both take effect and the count is unchanged. This is legal only when the branch is not full.
- Full branch: IN_READY stays 0 for that select even if the consumer pops in the same cycle. There is no pass-through from pop to push.
- Empty branch: there is no bypass. A word is never visible on the output in the cycle it is pushed.
- The two branches pop independently. Both may pop in the same cycle as a push to either branch.
- FLUSH: at the next edge, both counts and all pointers go to 0. The data registers are not cleared. In a FLUSH cycle no push or pop takes effect, whatever IN_VALID or OUTn_READY are doing.
- OUTn_DATA = mem_n[rd_ptr_n] when count_n != 0, otherwise 0.
- Outputs after RESET: IN_READY = 1 (if FLUSH = 0), OUTn_VALID = 0, OUTn_DATA = 0, OUTn_COUNT = 0. Pointers and memory are cleared to 0.
- RESET mid-transfer: in-flight words are discarded. Behaviour is the same as from power-up.

## Timing
- Latency: a word accepted at edge N is on OUTn_DATA with OUTn_VALID = 1 immediately after edge N. The consumer can take it at edge N+1.
- Throughput: one push per cycle in total, and one pop per cycle per branch.
- A pop at edge N frees space; IN_READY for that branch rises after edge N.
- OUTn_VALID, OUTn_COUNT and OUTn_DATA are functions of registered state only, with no combinational path from the inputs.
- IN_READY is the only output with a combinational path from the inputs: from IN_SELECT and from FLUSH.

## Test plan
- Reset and idle: assert RESET mid-cycle, then release.
  -> Immediately after assertion, all VALID = 0, counts = 0 and OUTn_DATA = 0.
  -> IN_READY = 1 for both select values.
- Routing:
  -> push 0xAAAA0001 with SEL = 0, then 0xBBBB0002 with SEL = 1, holding both READY signals high.
  -> OUT1 shows 0xAAAA0001 one cycle after its push; OUT2 shows 0xBBBB0002 one cycle after its push.
  -> Neither word ever appears on the other branch.
- Full and backpressure: with OUT1_READY = 0, push 0x11 and then 0x22 to branch 1.
  -> OUT1_COUNT = 2 and IN_READY = 0 for SEL = 0, but IN_READY = 1 for SEL = 1, and a push of 0x33 to branch 2 is accepted.
  -> Raising OUT1_READY drains 0x11 and then 0x22 in order.
- Simultaneous push and pop: branch 1 holds 1 entry (0x44); push 0x55 while popping.
  -> Count stays at 1 and the head becomes 0x55.
  -> Repeat 8 times with incrementing data to exercise pointer wrap; the outputs match the input order.
- FLUSH: both branches full, assert FLUSH together with IN_VALID = 1 and both READY = 1.
  -> Next cycle both counts = 0 and both VALID = 0; nothing was pushed or popped.
  -> IN_READY was 0 during the FLUSH cycle.
- Randomized traffic against a queue model: 10000 cycles of random SEL, VALID and READY, with FLUSH at 1% probability.
  -> No word is lost, duplicated or reordered between flushes.
